// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clk_div_bank divider bank.
package clk_div_pkg;

  localparam int DEF_HALF_C = 0;
  localparam int MAX_CH     = 8;
  localparam int CH_MAX_W   = 3;
  localparam int HALF_MAX_W = 16;

  typedef struct packed {
    logic [CH_MAX_W-1:0]   ch;
    logic [HALF_MAX_W-1:0] half;
  } cfg_req_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Config write port of clk_div_bank: valid/ready transfer of {channel, half-period}.
interface clk_div_bank_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            cfg_valid;
  logic            cfg_ready;
  logic [CH_W-1:0] cfg_ch;
  logic [DIV_W-1:0] cfg_half;

  modport master (output cfg_valid, output cfg_ch, output cfg_half, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ch, input cfg_half, output cfg_ready);
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: phase counter, half-period register, 50% toggle and rising-edge tick.
// A pending half-period is taken at the channel's own wrap so no short pulse is produced.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W    = 8,
  parameter int DEF_HALF = DEF_HALF_C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             sync_clr,
  input  logic             sync_all,
  input  logic             apply_req,
  input  logic [DIV_W-1:0] apply_half,
  output logic             apply_ack,
  output logic             rise,
  output logic             div_out,
  output logic             tick
);

  logic [DIV_W-1:0] phase_q;
  logic [DIV_W-1:0] half_q;
  logic             div_q;
  logic             tick_q;
  logic             wrap;
  logic             hold_clr;

  assign wrap      = (phase_q == half_q);
  assign hold_clr  = sync_clr | sync_all;
  // while frozen the new value is taken immediately and the phase restarts
  assign apply_ack = apply_req & ~hold_clr & (ena ? wrap : 1'b1);
  assign rise      = ~hold_clr & ena & wrap & ~div_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      half_q  <= DIV_W'(DEF_HALF);
      div_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else if (hold_clr) begin
      phase_q <= '0;
      div_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else if (ena) begin
      tick_q <= rise;
      if (wrap) begin
        phase_q <= '0;
        div_q   <= ~div_q;
        if (apply_req) half_q <= apply_half;
      end else begin
        phase_q <= phase_q + DIV_W'(1);
      end
    end else begin
      tick_q <= 1'b0;
      if (apply_req) begin
        half_q  <= apply_half;
        phase_q <= '0;
      end
    end
  end

  assign div_out = div_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH synchronous 50% clock dividers with single-slot runtime config and a tick[0] counter.
// Optional: CLK_DIV_SYNC_ALL_EN adds a sync_all input that realigns every channel in one edge.
//
// state      | meaning
// SLOT_EMPTY | no pending config, cfg_ready high unless sync_clr
// SLOT_FULL  | request waiting for its target channel's next wrap
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 8,
  parameter int CNT_W    = 4,
  parameter int DEF_HALF = DEF_HALF_C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              sync_clr,
`ifdef CLK_DIV_SYNC_ALL_EN
  input  logic              sync_all,
`endif
  clk_div_bank_if.slave     cfg,
  output logic [NUM_CH-1:0] div_out,
  output logic [NUM_CH-1:0] tick,
  output logic [CNT_W-1:0]  cnt
);

  localparam int CH_W    = ch_width(NUM_CH);
  localparam int CH_SPAN = 1 << CH_W;

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("clk_div_bank: NUM_CH out of range");
  end
  if (DIV_W > HALF_MAX_W) begin : g_bad_div_w
    $error("clk_div_bank: DIV_W wider than cfg_req_t.half");
  end

  slot_state_t       state_q, state_d;
  cfg_req_t          pend_q, pend_d;
  logic [CH_SPAN-1:0] ch_ok;
  logic [NUM_CH-1:0] apply_req;
  logic [NUM_CH-1:0] apply_ack;
  logic [NUM_CH-1:0] rise_all;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;
  logic              sync_all_i;
  logic              unused_bits;

`ifdef CLK_DIV_SYNC_ALL_EN
  assign sync_all_i = sync_all;
`else
  assign sync_all_i = 1'b0;
`endif

  for (genvar g = 0; g < CH_SPAN; g++) begin : g_ch_ok
    assign ch_ok[g] = (g < NUM_CH);
  end

  assign cfg.cfg_ready = (state_q == SLOT_EMPTY) & ~sync_clr;
  assign accept        = cfg.cfg_valid & cfg.cfg_ready;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      SLOT_EMPTY: begin
        // out-of-range channels complete the handshake but are never stored
        if (accept && ch_ok[cfg.cfg_ch]) begin
          state_d     = SLOT_FULL;
          pend_d.ch   = CH_MAX_W'(cfg.cfg_ch);
          pend_d.half = HALF_MAX_W'(cfg.cfg_half);
        end
      end
      SLOT_FULL: begin
        if (|apply_ack) state_d = SLOT_EMPTY;
      end
      default: state_d = SLOT_EMPTY;
    endcase
    if (sync_clr) state_d = SLOT_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    assign apply_req[g] = (state_q == SLOT_FULL) && (pend_q.ch == CH_MAX_W'(g));

    clk_div_chan #(
      .DIV_W    (DIV_W),
      .DEF_HALF (DEF_HALF)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .sync_clr   (sync_clr),
      .sync_all   (sync_all_i),
      .apply_req  (apply_req[g]),
      .apply_half (pend_q.half[DIV_W-1:0]),
      .apply_ack  (apply_ack[g]),
      .rise       (rise_all[g]),
      .div_out    (div_out[g]),
      .tick       (tick[g])
    );
  end

  // cnt steps on the same edge that raises tick[0]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (sync_clr) begin
      cnt_q <= '0;
    end else if (rise_all[0]) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt = cnt_q;

  // upper struct bits and the other channels' rise flags are intentionally left unread
  assign unused_bits = ^{pend_q, rise_all};

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: directed scenarios followed by random stimulus,
// checked cycle by cycle against a countdown-based behavioural model.
module tb_clk_div_bank;

  localparam int N_CH  = 3;
  localparam int DIV_W = 8;
  localparam int CNT_W = 4;
  localparam int DEFH  = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic sync_clr = 1'b0;
  logic sync_all_v = 1'b0;
  logic [N_CH-1:0]  div_out;
  logic [N_CH-1:0]  tick;
  logic [CNT_W-1:0] cnt;

  clk_div_bank_if #(.NUM_CH(N_CH), .DIV_W(DIV_W)) cfg_if ();

  clk_div_bank #(
    .NUM_CH   (N_CH),
    .DIV_W    (DIV_W),
    .CNT_W    (CNT_W),
    .DEF_HALF (DEFH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .sync_clr (sync_clr),
`ifdef CLK_DIV_SYNC_ALL_EN
    .sync_all (sync_all_v),
`endif
    .cfg      (cfg_if),
    .div_out  (div_out),
    .tick     (tick),
    .cnt      (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_CH-1:0]  div;
    logic [N_CH-1:0]  tck;
    logic [CNT_W-1:0] cnt;
    logic             rdy;
  } exp_t;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] half;
  } req_t;

  exp_t sb[$];
  req_t req_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // model: cycles left in the current half-period per channel
  int m_h [N_CH];
  int m_left [N_CH];
  bit m_div [N_CH];
  bit m_tick [N_CH];
  int m_cnt;
  bit m_full;
  int m_pch;
  int m_phalf;

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_h[i] = DEFH; m_left[i] = DEFH + 1; m_div[i] = 1'b0; m_tick[i] = 1'b0;
    end
    m_cnt = 0;
    m_full = 1'b0;
  endtask

  task automatic model_edge();
    bit acc;
    bit applied;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (sync_clr) begin
      for (int i = 0; i < N_CH; i++) begin
        m_left[i] = m_h[i] + 1; m_div[i] = 1'b0; m_tick[i] = 1'b0;
      end
      m_cnt = 0;
      m_full = 1'b0;
      return;
    end
    acc = cfg_if.cfg_valid && !m_full;
    applied = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      m_tick[i] = 1'b0;
      if (sync_all_v) begin
        m_left[i] = m_h[i] + 1;
        m_div[i] = 1'b0;
      end else if (ena) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          if (m_full && m_pch == i) begin
            m_h[i] = m_phalf;
            applied = 1'b1;
          end
          m_div[i] = !m_div[i];
          m_tick[i] = m_div[i];
          m_left[i] = m_h[i] + 1;
        end
      end else if (m_full && m_pch == i) begin
        m_h[i] = m_phalf;
        m_left[i] = m_h[i] + 1;
        applied = 1'b1;
      end
    end
    if (m_tick[0]) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    if (applied) m_full = 1'b0;
    if (acc) begin
      void'(req_q.pop_front());
      if (int'(cfg_if.cfg_ch) < N_CH) begin
        m_full = 1'b1;
        m_pch = int'(cfg_if.cfg_ch);
        m_phalf = int'(cfg_if.cfg_half);
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    for (int i = 0; i < N_CH; i++) begin
      e.div[i] = m_div[i];
      e.tck[i] = m_tick[i];
    end
    e.cnt = CNT_W'(m_cnt);
    e.rdy = !m_full && !sync_clr;
    sb.push_back(e);
  endtask

  task automatic issue(input int ch, input int half);
    req_t r;
    r.ch = 2'(ch);
    r.half = 8'(half);
    req_q.push_back(r);
  endtask

  // drive inputs for one cycle, queue its expected outputs, then advance the model over the edge
  task automatic run_cycle(input bit rn, input bit e, input bit sc, input bit sa);
    rst_n = rn; ena = e; sync_clr = sc; sync_all_v = sa;
    if (!rn) model_reset();
    cfg_if.cfg_valid = (req_q.size() != 0);
    if (req_q.size() != 0) begin
      cfg_if.cfg_ch = req_q[0].ch;
      cfg_if.cfg_half = req_q[0].half;
    end
    push_expected();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run_n(input int n, input bit e);
    for (int k = 0; k < n; k++) run_cycle(1'b1, e, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("div_out", int'(div_out), int'(e.div));
      check("tick", int'(tick), int'(e.tck));
      check("cnt", int'(cnt), int'(e.cnt));
      check("cfg_ready", int'(cfg_if.cfg_ready), int'(e.rdy));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch = '0;
    cfg_if.cfg_half = '0;
    model_reset();
    @(posedge clk);
    #1;
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0);

    // divide-by-2 everywhere; 40 cycles take cnt through its wrap
    run_n(40, 1'b1);

    // ch1 to H=3 while running
    issue(1, 3);
    run_n(30, 1'b1);

    // back-to-back writes, the second stalls on the full slot
    issue(0, 2);
    issue(2, 5);
    run_n(60, 1'b1);

    // freeze mid-period, then resume
    run_n(3, 1'b1);
    run_n(10, 1'b0);
    run_n(20, 1'b1);

    // sync_clr landing on a ch0 wrap with a pending slot and a live request
    issue(2, 9);
    run_n(1, 1'b1);
    for (int k = 0; k < 40 && m_left[0] != 1; k++) run_n(1, 1'b1);
    issue(1, 4);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    run_n(20, 1'b1);

    // async reset between edges, held two cycles
    run_n(5, 1'b1);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run_n(20, 1'b1);

    // config applied while frozen
    issue(0, 4);
    run_n(3, 1'b0);
    run_n(20, 1'b1);

`ifdef CLK_DIV_SYNC_ALL_EN
    issue(0, 0);
    issue(1, 1);
    issue(2, 2);
    run_n(40, 1'b1);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    run_n(20, 1'b1);
`endif

    for (int k = 0; k < 1500; k++) begin
      bit e;
      bit sc;
      bit sa;
      bit rn;
      e = ($urandom_range(0, 15) != 0);
      sc = ($urandom_range(0, 63) == 0);
      sa = 1'b0;
`ifdef CLK_DIV_SYNC_ALL_EN
      sa = ($urandom_range(0, 49) == 0);
`endif
      rn = ($urandom_range(0, 499) != 0);
      if (req_q.size() == 0 && $urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 7) == 0) issue($urandom_range(0, 3), $urandom_range(0, 20));
        else issue($urandom_range(0, 3), $urandom_range(0, 7));
      end
      run_cycle(rn, e, sc, sa);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
